// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the player-side sequence checker:
//   - direction encodings (2 bits per step)
//   - key indices of the 4-button KEY vector
//   - checker state enum
//   - small helpers to turn a press vector into a direction / multi-key flag
// -----------------------------------------------------------------------------
package game_pkg;

  localparam int KEY_COUNT = 4;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_WAIT_PRESS   = 2'b01,
    ST_WAIT_RELEASE = 2'b10
  } chk_state_t;

  // Priority-encode a press vector; with several bits set the lowest index wins.
  function automatic logic [1:0] key_to_dir(input logic [KEY_COUNT-1:0] keys);
    logic [1:0] dir;
    dir = DIR_RIGHT;
    if (keys[KEY_UP]) begin
      dir = DIR_UP;
    end else if (keys[KEY_DOWN]) begin
      dir = DIR_DOWN;
    end else if (keys[KEY_LEFT]) begin
      dir = DIR_LEFT;
    end else begin
      dir = DIR_RIGHT;
    end
    return dir;
  endfunction

  // True when two or more bits of the press vector are set.
  function automatic logic more_than_one(input logic [KEY_COUNT-1:0] keys);
    return (keys & (keys - KEY_COUNT'(1))) != '0;
  endfunction

endpackage

// File: rtl/key_press_detector.sv
// -----------------------------------------------------------------------------
// key_press_detector
// Per-key 2-flop synchronizer, debounce counter and rising-edge detector.
//   i_clock  : system clock
//   i_reset  : asynchronous active-high reset
//   i_keys   : raw active-high buttons, asynchronous to i_clock
//   o_level  : debounced key levels
//   o_press  : one-cycle strobe per key on a debounced 0->1 transition
// A debounced level flips only after DEBOUNCE_CYCLES consecutive synchronized
// samples that disagree with it; o_press is registered together with the flip.
// -----------------------------------------------------------------------------
module key_press_detector #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_keys,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_press;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  // Two-flop synchronizer for the asynchronous buttons.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_keys;
      r_sync <= r_meta;
    end
  end

  // Debounce: count consecutive disagreeing samples, flip level on the last one.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_level <= '0;
      r_press <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync[i] != r_level[i]) begin
          if (r_cnt[i] == CNT_LAST) begin
            r_level[i] <= r_sync[i];
            r_press[i] <= r_sync[i];
            r_cnt[i]   <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/player_sequence_checker.sv
// -----------------------------------------------------------------------------
// player_sequence_checker
// Latches the played direction sequence on i_begin_signal and checks the
// player's key presses against it step by step.
//   i_clock, i_reset   : clock, asynchronous active-high reset
//   i_begin_signal     : one-cycle start pulse (latches i_sequence, restarts)
//   i_sequence         : expected directions, step 0 in the MSBs
//   i_keys             : raw buttons [0] up [1] down [2] left [3] right
//   o_busy             : check in progress
//   o_step_index       : number of correct presses so far
//   o_last_direction   : direction of the most recent accepted press
//   o_press_pulse      : one-cycle strobe per accepted press
//   o_pass             : sticky, whole sequence matched
//   o_fail             : sticky, wrong key / multiple keys / timeout
//   o_fail_timeout     : sticky, the failure was a timeout
// -----------------------------------------------------------------------------
module player_sequence_checker
  import game_pkg::*;
#(
  parameter  int NUM_STEPS       = 4,
  parameter  int DIR_W           = 2,
  parameter  int DEBOUNCE_CYCLES = 500000,
  parameter  int TIMEOUT_CYCLES  = 150000000,
  localparam int STEP_W          = $clog2(NUM_STEPS + 1)
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_begin_signal,
  input  logic [NUM_STEPS*DIR_W-1:0] i_sequence,
  input  logic [3:0]                 i_keys,
  output logic                       o_busy,
  output logic [STEP_W-1:0]          o_step_index,
  output logic [DIR_W-1:0]           o_last_direction,
  output logic                       o_press_pulse,
  output logic                       o_pass,
  output logic                       o_fail,
  output logic                       o_fail_timeout
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STEP_W-1:0]  STEP_DONE  = STEP_W'(NUM_STEPS);

  chk_state_t                 r_state;
  logic [NUM_STEPS*DIR_W-1:0] r_seq;
  logic [STEP_W-1:0]          r_step;
  logic [TIMER_W-1:0]         r_timer;
  logic [DIR_W-1:0]           r_last_dir;
  logic                       r_pulse;
  logic                       r_pass;
  logic                       r_fail;
  logic                       r_fail_timeout;
  logic                       r_busy;

  logic [3:0]       w_level;
  logic [3:0]       w_press;
  logic [DIR_W-1:0] w_dir;
  logic [DIR_W-1:0] w_expected;
  logic [STEP_W-1:0] w_step_inc;
  logic             w_any_press;
  logic             w_multi;

  key_press_detector #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_keys (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_keys  (i_keys),
    .o_level (w_level),
    .o_press (w_press)
  );

  assign w_any_press = |w_press;
  assign w_multi     = more_than_one(w_press);
  assign w_dir       = DIR_W'(key_to_dir(w_press));
  assign w_step_inc  = r_step + STEP_W'(1);

  // Select the latched direction for the current step (step 0 sits in the MSBs).
  always_comb begin
    w_expected = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      w_expected = w_expected |
                   ((r_step == STEP_W'(i)) ? r_seq[(NUM_STEPS-1-i)*DIR_W +: DIR_W] : '0);
    end
  end

  // Checker FSM with registered outputs; begin_signal overrides everything.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_seq          <= '0;
      r_step         <= '0;
      r_timer        <= '0;
      r_last_dir     <= '0;
      r_pulse        <= 1'b0;
      r_pass         <= 1'b0;
      r_fail         <= 1'b0;
      r_fail_timeout <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (i_begin_signal) begin
        r_seq          <= i_sequence;
        r_step         <= '0;
        r_timer        <= '0;
        r_pass         <= 1'b0;
        r_fail         <= 1'b0;
        r_fail_timeout <= 1'b0;
        r_busy         <= 1'b1;
        r_state        <= ST_WAIT_PRESS;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_busy <= 1'b0;
          end
          ST_WAIT_PRESS: begin
            // A press on the terminal-count cycle still counts as a press.
            if (w_any_press) begin
              r_pulse    <= 1'b1;
              r_last_dir <= w_dir;
              if (!w_multi && (w_dir == w_expected)) begin
                r_step  <= w_step_inc;
                r_timer <= '0;
                if (w_step_inc == STEP_DONE) begin
                  r_pass  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
                end else begin
                  r_state <= ST_WAIT_RELEASE;
                end
              end else begin
                r_fail  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end
            end else if (r_timer == TIMER_LAST) begin
              r_fail         <= 1'b1;
              r_fail_timeout <= 1'b1;
              r_busy         <= 1'b0;
              r_state        <= ST_IDLE;
            end else begin
              r_timer <= r_timer + TIMER_W'(1);
            end
          end
          ST_WAIT_RELEASE: begin
            // New presses are ignored until every debounced key is released.
            if (r_timer == TIMER_LAST) begin
              r_fail         <= 1'b1;
              r_fail_timeout <= 1'b1;
              r_busy         <= 1'b0;
              r_state        <= ST_IDLE;
            end else begin
              r_timer <= r_timer + TIMER_W'(1);
              if (w_level == 4'b0000) begin
                r_state <= ST_WAIT_PRESS;
              end else begin
                r_state <= ST_WAIT_RELEASE;
              end
            end
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_busy           = r_busy;
  assign o_step_index     = r_step;
  assign o_last_direction = r_last_dir;
  assign o_press_pulse    = r_pulse;
  assign o_pass           = r_pass;
  assign o_fail           = r_fail;
  assign o_fail_timeout   = r_fail_timeout;

endmodule

// File: tb/tb_player_sequence_checker.sv
// -----------------------------------------------------------------------------
// tb_player_sequence_checker
// Directed stimulus against player_sequence_checker (DEBOUNCE_CYCLES=4,
// TIMEOUT_CYCLES=100). A behavioural model tracks the expected outputs from a
// sliding window of raw key samples and the game rules; every cycle the DUT
// outputs are compared with it, and hand-computed literals pin key moments.
// -----------------------------------------------------------------------------
module tb_player_sequence_checker;

  localparam int NS = 4;
  localparam int DB = 4;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       begin_sig;
  logic [7:0] seq_in;
  logic [3:0] keys;
  logic       busy;
  logic [2:0] step_index;
  logic [1:0] last_dir;
  logic       press_pulse;
  logic       pass_o;
  logic       fail_o;
  logic       fail_to;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  player_sequence_checker #(
    .NUM_STEPS       (NS),
    .DIR_W           (2),
    .DEBOUNCE_CYCLES (DB),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_begin_signal   (begin_sig),
    .i_sequence       (seq_in),
    .i_keys           (keys),
    .o_busy           (busy),
    .o_step_index     (step_index),
    .o_last_direction (last_dir),
    .o_press_pulse    (press_pulse),
    .o_pass           (pass_o),
    .o_fail           (fail_o),
    .o_fail_timeout   (fail_to)
  );

  // ---------------- model state ----------------
  logic [3:0] m_hist [DB+2];  // m_hist[0] = raw keys sampled at the latest edge
  logic [3:0] m_level;
  logic [3:0] m_press;
  int         m_state;        // 0 idle, 1 waiting for press, 2 waiting for release
  logic [7:0] m_seq;
  int         m_step;
  int         m_timer;
  logic [1:0] m_last;
  logic       m_pulse, m_pass, m_fail, m_ft;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DB + 2; i++) m_hist[i] = 4'b0000;
    m_level = 4'b0000; m_press = 4'b0000; m_state = 0; m_seq = 8'h00;
    m_step = 0; m_timer = 0; m_last = 2'b00;
    m_pulse = 1'b0; m_pass = 1'b0; m_fail = 1'b0; m_ft = 1'b0;
  endtask

  task automatic model_step(input logic b, input logic [7:0] sq, input logic [3:0] raw);
    logic [3:0] p;
    logic [3:0] newlvl;
    int dir;
    int expd;
    logic all1, all0;
    p = m_press;
    m_pulse = 1'b0;
    if (b) begin
      m_seq = sq; m_step = 0; m_timer = 0; m_state = 1;
      m_pass = 1'b0; m_fail = 1'b0; m_ft = 1'b0;
    end else if (m_state == 1) begin
      if (p != 4'b0000) begin
        dir = 0;
        for (int k = 3; k >= 0; k--) if (p[k]) dir = k;
        expd = (m_seq >> (2 * (NS - 1 - m_step))) & 8'h03;
        m_pulse = 1'b1;
        m_last = dir[1:0];
        if ($countones(p) == 1 && dir == expd) begin
          m_step++;
          m_timer = 0;
          if (m_step == NS) begin m_pass = 1'b1; m_state = 0; end
          else m_state = 2;
        end else begin
          m_fail = 1'b1; m_state = 0;
        end
      end else if (m_timer == TO - 1) begin
        m_fail = 1'b1; m_ft = 1'b1; m_state = 0;
      end else begin
        m_timer++;
      end
    end else if (m_state == 2) begin
      if (m_timer == TO - 1) begin
        m_fail = 1'b1; m_ft = 1'b1; m_state = 0;
      end else begin
        m_timer++;
        if (m_level == 4'b0000) m_state = 1;
      end
    end
    // Debounced level follows the raw key once DB samples, seen 2 cycles late, agree.
    for (int i = DB + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = raw;
    newlvl = m_level;
    for (int k = 0; k < 4; k++) begin
      all1 = 1'b1; all0 = 1'b1;
      for (int j = 2; j < DB + 2; j++) begin
        all1 = all1 & m_hist[j][k];
        all0 = all0 & ~m_hist[j][k];
      end
      if (all1) newlvl[k] = 1'b1;
      else if (all0) newlvl[k] = 1'b0;
    end
    m_press = newlvl & ~m_level;
    m_level = newlvl;
  endtask

  // Model update on every rising edge, then cycle-by-cycle comparison.
  initial begin : model_compare
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step(begin_sig, seq_in, keys);
      #1;
      chk("busy", busy, (m_state != 0) ? 1 : 0);
      chk("step_index", step_index, m_step);
      chk("last_direction", last_dir, m_last);
      chk("press_pulse", press_pulse, m_pulse);
      chk("pass", pass_o, m_pass);
      chk("fail", fail_o, m_fail);
      chk("fail_timeout", fail_to, m_ft);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_begin(input logic [7:0] s);
    @(negedge clk);
    seq_in = s;
    begin_sig = 1'b1;
    @(negedge clk);
    begin_sig = 1'b0;
  endtask

  task automatic press(input int k);
    keys = 4'b0001 << k;
    repeat (10) @(negedge clk);
    keys = 4'b0000;
    repeat (10) @(negedge clk);
  endtask

  int pulses;

  initial begin : stimulus
    rst = 1'b1; begin_sig = 1'b0; seq_in = 8'h00; keys = 4'b0000;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_step", step_index, 0);
    chk("reset_pass", pass_o, 0);
    chk("reset_fail", fail_o, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Correct round: up, right, down, left.
    do_begin(8'b00_11_01_10);
    chk("round_busy", busy, 1);
    press(0); chk("round_step1", step_index, 1);
    press(3); chk("round_step2", step_index, 2);
    press(1); chk("round_step3", step_index, 3);
    press(2); chk("round_step4", step_index, 4);
    chk("round_pass", pass_o, 1);
    chk("round_fail", fail_o, 0);
    chk("round_busy_end", busy, 0);

    // Wrong key: up then left.
    do_begin(8'b00_11_01_10);
    press(0);
    press(2);
    chk("wrong_step", step_index, 1);
    chk("wrong_fail", fail_o, 1);
    chk("wrong_timeout", fail_to, 0);
    chk("wrong_busy", busy, 0);
    chk("wrong_lastdir", last_dir, 2);

    // Timeout: fail exactly TO cycles after entering the wait state.
    do_begin(8'h00);
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      if (c == TO - 1) chk("timeout_early", fail_o, 0);
      if (c == TO) begin
        chk("timeout_fail", fail_o, 1);
        chk("timeout_flag", fail_to, 1);
      end
    end
    repeat (3) @(negedge clk);

    // Glitch gives no strobe; a long hold gives exactly one.
    do_begin(8'h00);
    pulses = 0;
    keys = 4'b0001;
    repeat (3) begin @(negedge clk); pulses += press_pulse; end
    keys = 4'b0000;
    repeat (15) begin @(negedge clk); pulses += press_pulse; end
    chk("glitch_pulses", pulses, 0);
    pulses = 0;
    keys = 4'b0001;
    repeat (50) begin @(negedge clk); pulses += press_pulse; end
    keys = 4'b0000;
    repeat (10) begin @(negedge clk); pulses += press_pulse; end
    chk("hold_pulses", pulses, 1);
    chk("hold_step", step_index, 1);

    // Two keys in the same cycle.
    do_begin(8'h00);
    keys = 4'b0011;
    repeat (10) @(negedge clk);
    keys = 4'b0000;
    repeat (10) @(negedge clk);
    chk("multi_fail", fail_o, 1);
    chk("multi_step", step_index, 0);

    // Restart mid-check with a new sequence; later sequence changes are ignored.
    do_begin(8'b00_11_01_10);
    press(0);
    press(3);
    chk("restart_step2", step_index, 2);
    do_begin(8'hFF);
    chk("restart_step0", step_index, 0);
    seq_in = 8'h00;
    for (int i = 0; i < 4; i++) press(3);
    chk("restart_pass", pass_o, 1);
    chk("restart_step4", step_index, 4);

    // Reset in the middle of a check clears everything at once.
    do_begin(8'h00);
    press(0);
    keys = 4'b0010;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_step", step_index, 0);
    chk("rst_lastdir", last_dir, 0);
    chk("rst_pulse", press_pulse, 0);
    chk("rst_pass", pass_o, 0);
    chk("rst_fail", fail_o, 0);
    chk("rst_timeout", fail_to, 0);
    keys = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_sequence_checker.md
Name: player_sequence_checker

Overview:
- Player-side counterpart of the automated sequence playback. Once playback stops, it latches the same packed direction sequence and accepts the player's key presses.
- Each press is compared against the expected direction, step by step. It reports pass, fail (wrong key or timeout), and the current step to the game controller and the display logic.
- Sits between the debounced KEY inputs and the game FSM.

Parameters:
- NUM_STEPS, 4, number of directions in one round.
- DIR_W, 2, bits per direction.
- DEBOUNCE_CYCLES, 500000, stable cycles required before a key change is accepted (10 ms at 50 MHz).
- TIMEOUT_CYCLES, 150000000, maximum idle cycles between accepted presses (3 s at 50 MHz).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- begin_signal  in  1  one-cycle start pulse; latches sequence and starts checking.
- sequence  in  NUM_STEPS*DIR_W  expected directions, step 0 in the MSBs, 2'b00 up, 01 down, 10 left, 11 right.
- keys  in  4  raw active-high buttons: [0] up, [1] down, [2] left, [3] right; asynchronous to clock.
- busy  out  1  high while a check is in progress.
- step_index  out  clog2(NUM_STEPS+1)  number of correct presses so far.
- last_direction  out  DIR_W  encoding of the most recent accepted press.
- press_pulse  out  1  one-cycle strobe per accepted press.
- pass  out  1  sticky: whole sequence matched.
- fail  out  1  sticky: wrong key, multiple keys, or timeout.
- fail_timeout  out  1  sticky: qualifies fail as a timeout.

Behaviour:
- Reset values (asynchronous): all outputs 0, state IDLE, latched sequence 0, timeout counter 0.
- Key path:
  - Each key goes through a 2-flop synchronizer, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
  - A press event is a 0->1 edge of the debounced level.
  - Latency from a stable raw press to the press event is DEBOUNCE_CYCLES+2 cycles. The FSM reacts one cycle later.
- Press qualification:
  - If exactly one key has a press event in a cycle, the press is valid; its direction is that key's index.
  - If two or more keys have press events in the same cycle, the press is invalid and is treated as a wrong key.
  - Any of these press events pulses press_pulse.
- IDLE:
  - busy=0; pass and fail keep their last values.
  - On begin_signal: latch sequence, clear pass/fail/fail_timeout/step_index and the timeout counter, go to WAIT_PRESS.
- WAIT_PRESS:
  - busy=1.
  - The timeout counter increments every cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 with no press: next cycle fail=1, fail_timeout=1, go to IDLE.
  - On a press event:
    - Update last_direction and pulse press_pulse.
    - If the direction equals latched step[step_index] and the press is valid: increment step_index and clear the timeout counter.
      - If the new step_index equals NUM_STEPS: set pass=1 and go to IDLE.
      - Otherwise go to WAIT_RELEASE.
    - Otherwise: set fail=1 and go to IDLE.
- WAIT_RELEASE:
  - busy=1; the timeout counter keeps running.
  - Return to WAIT_PRESS when all debounced keys are 0.
  - Further press events are ignored (no strobe).
  - Timeout behaves the same as in WAIT_PRESS.
- All state, step_index, pass and fail updates are visible the cycle after the press event.
- Simultaneous events:
  - begin_signal wins over a press event and over a timeout in the same cycle. It restarts from step 0 in any state, including mid-check.
  - A press event in the same cycle as the timeout terminal count is evaluated as a press; the timeout is ignored.
- Reset mid-check aborts immediately. No pass or fail is reported.
- sequence changes after begin_signal have no effect, because the checker uses the latched copy.

Decomposition:
- Shared package game_pkg:
  - Direction encodings DIR_UP/DOWN/LEFT/RIGHT.
  - Key-index constants.
  - Checker state enum (IDLE, WAIT_PRESS, WAIT_RELEASE).
- Sub-module key_press_detector, instantiated once with width 4: synchronizer, debounce counters, rising-edge output vector. It has its own reset and clock ports.
- All other logic stays in one FSM module.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100):
- Correct round: sequence=8'b00_11_01_10, begin, then press up, right, down, left (each held 10 cycles, released 10 cycles) -> step_index 1,2,3,4; pass=1, fail=0 after the 4th press; busy=0.
- Wrong key: sequence=8'b00_11_01_10, press up then left -> step_index stays 1; fail=1, fail_timeout=0, busy drops the cycle after the left press event.
- Timeout and bounce:
  - Begin, then no presses -> fail=1, fail_timeout=1 exactly 100 cycles after WAIT_PRESS entry.
  - A 3-cycle glitch on keys[0] -> no press_pulse.
- Multi-key and hold:
  - Press up and down in the same cycle -> fail=1.
  - A single key held 50 cycles -> exactly one press_pulse.
- Restart and reset:
  - begin_signal at step_index=2 with a new sequence=8'hFF -> step_index=0; four right presses -> pass=1.
  - Assert reset mid-check -> all outputs 0 asynchronously.
